// File: rtl/divider_4bit_seq.sv
// rtl/divider_4bit_seq.sv - sequential restoring divider, one quotient bit per clock
// Start/done handshake; divide-by-zero yields all-ones quotient and remainder = dividend.
module divider_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qsh_q, qsh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      qsh_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      qsh_q   <= qsh_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Shifted partial remainder with the next dividend bit, trial-subtracted at WIDTH+1 bits.
  always_comb begin
    trial   = {rem_q, qsh_q[WIDTH-1]};
    diff    = trial - {1'b0, dvs_q};
    state_d = state_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            qsh_d   = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        qsh_d = {qsh_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          quo_d   = qsh_d;
          rmd_d   = rem_d;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_CALC);
  assign done        = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb/tb_divider_4bit_seq.sv - directed and exhaustive bench for divider_4bit_seq
// Drives and samples on the falling edge; expected results come from the / and % operators.
module tb_divider_4bit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  logic       start8;
  logic [7:0] dividend8, divisor8;
  logic       busy8, done8, dbz8;
  logic [7:0] quotient8, remainder8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  divider_4bit_seq #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  divider_4bit_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from a falling edge in IDLE; returns on the falling edge after done.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit glitch);
    logic [3:0] eq, er;
    logic       edz;
    int         elat, n, bcnt;
    if (b == 4'd0) begin
      eq = 4'hF; er = a; edz = 1'b1; elat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; elat = 4;
    end
    if (glitch) begin
      eq = 4'd3; er = 4'd2; edz = 1'b0; elat = 4;
    end
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    n = 0; bcnt = 0;
    while (!done && n < 20) begin
      if (busy) bcnt++;
      if (glitch && n == 1) begin
        start = 1'b1; dividend = 4'd9; divisor = 4'd3;
      end
      @(negedge clk);
      if (glitch && n == 1) begin
        start = 1'b0; dividend = 4'd1; divisor = 4'd1;
      end
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", n, elat);
    check("busy_cycles", bcnt, elat);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("quotient", {28'd0, quotient}, {28'd0, eq});
    check("remainder", {28'd0, remainder}, {28'd0, er});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("q_hold", {28'd0, quotient}, {28'd0, eq});
    check("r_hold", {28'd0, remainder}, {28'd0, er});
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq, er;
    int         elat, n;
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; elat = 0;
    end else begin
      eq = a / b; er = a % b; elat = 8;
    end
    start8 = 1'b1; dividend8 = a; divisor8 = b;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("w8_latency", n, elat);
    check("w8_quotient", {24'd0, quotient8}, {24'd0, eq});
    check("w8_remainder", {24'd0, remainder8}, {24'd0, er});
    check("w8_div_by_zero", {31'd0, dbz8}, {31'd0, (b == 8'd0)});
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", {28'd0, quotient}, 32'd0);
    check("rst_r", {28'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'd13, 4'd3, 1'b0);
    do_op(4'd15, 4'd1, 1'b0);
    do_op(4'd3,  4'd7, 1'b0);
    do_op(4'd0,  4'd5, 1'b0);
    do_op(4'd15, 4'd15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_hold_q", {28'd0, quotient}, 32'd1);
      check("idle_hold_r", {28'd0, remainder}, 32'd0);
    end
    do_op(4'd7, 4'd0, 1'b0);
    do_op(4'd8, 4'd2, 1'b0);

    do_op(4'd14, 4'd4, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    check("no_second_op", {31'd0, seen}, 32'd0);

    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_q", {28'd0, quotient}, 32'd0);
    check("mid_rst_r", {28'd0, remainder}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, seen}, 32'd0);
    do_op(4'd12, 4'd5, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), 1'b0);
      end
    end

    do_op8(8'd255, 8'd1);
    do_op8(8'd200, 8'd0);
    do_op8(8'd7, 8'd200);
    for (int i = 0; i < 100; i++) begin
      do_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    n = tests;
    $display("[TB] %0d tests run, %0d failed", n, fails);
    $finish;
  end

endmodule

// File: doc/divider_4bit_seq.md
Name: divider_4bit_seq

Overview:
- Sequential restoring divider. It is the inverse-direction companion to the team's combinational 4-bit array multiplier.
- Takes an unsigned dividend and divisor and produces quotient and remainder. Resolves one quotient bit per clock, so an operation costs WIDTH cycles.
- Uses a start/done handshake so datapath control logic can issue an operation and then wait for it.
- Intended to check and invert multiplier results in the arithmetic datapath: p / b = a, remainder 0.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder. Minimum 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled on a rising clk edge only in IDLE.
- dividend  input  WIDTH  unsigned dividend. Sampled together with start.
- divisor  input  WIDTH  unsigned divisor. Sampled together with start.
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  single-cycle pulse; quotient and remainder are valid.
- quotient  output  WIDTH  result quotient. Holds its value until the next done.
- remainder  output  WIDTH  result remainder. Holds its value until the next done.
- div_by_zero  output  1  high alongside a done caused by divisor==0. Holds like the results.

Behaviour:
- Reset: one clock and one reset. Reset is asynchronous and active-high on rst.
  - While rst is high: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal registers = 0.
  - Reset asserted mid-operation aborts that operation immediately. No done is produced for it.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 with divisor!=0: latch dividend into the quotient shift register, latch divisor, clear the partial remainder, load count=WIDTH, go to CALC.
  - start=1 with divisor==0: go straight to DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- CALC (busy=1), on each edge:
  - Shift {partial_rem, q_shift} left by 1.
  - Trial-subtract the divisor from the shifted partial remainder, computed at WIDTH+1 bits.
  - If the result is non-negative: take the difference and set the new q LSB to 1. Otherwise restore and set the LSB to 0.
  - Decrement count. When count reaches 1, this edge is the last: register quotient/remainder and go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
  - div_by_zero is cleared at the next accepted start.
- Latency, counting the edge that samples start as edge 0:
  - Normal operation: done is high in the cycle following edge WIDTH, i.e. WIDTH edges after acceptance (4 for the default).
  - Divide-by-zero: done is high after edge 0, i.e. one cycle.
  - Next start is accepted at the earliest one cycle after done, back in IDLE.
- Ignored starts: start in CALC or DONE is ignored and not queued. Operand changes during CALC have no effect because operands are latched.
- Arithmetic (unsigned only):
  - Invariant on done: dividend == quotient*divisor + remainder, with remainder < divisor when divisor != 0.
  - No overflow is possible for divisor ≥ 1.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Back-to-back operations: done and a new start cannot coincide because start is only honoured in IDLE.

Test Plan:
- Basic division: rst pulse, then start with 13/3 → done exactly 4 edges after the start edge with quotient=4, remainder=1, div_by_zero=0. busy high for 4 cycles; done high 1 cycle.
- Edge values:
  - 15/1 → q=15, r=0.
  - 3/7 → q=0, r=3.
  - 0/5 → q=0, r=0.
  - 15/15 → q=1, r=0.
  - Check each result is held stable after done until the next start.
- Divide by zero: start with 7/0 → done one cycle after the start edge with q=4'hF, r=7, div_by_zero=1. A following start with 8/2 → div_by_zero returns to 0; q=4, r=0.
- Ignored start and operand changes: start 14/4; at edge 2 pulse start with 9/3 and also change the dividend/divisor inputs → single done with q=3, r=2; no second done.
- Reset mid-operation: start 12/5; assert rst asynchronously between edges 2 and 3 → busy/done/q/r drop to 0 immediately, no done appears. After release, start 12/5 → q=2, r=2.
- Exhaustive check: all 256 dividend/divisor pairs for WIDTH=4, issued back-to-back as fast as IDLE permits. Compare against the reference model (dividend/divisor, dividend%divisor; div0 → all-ones, dividend). Also run a randomized subset at WIDTH=8.
